// File: rtl/weight_loader_if.sv
// weight_loader_if
//   Groups the word stream into the loader and the bank write bus out of it.
//   Signals:
//     s_data   stream word (header or payload)
//     s_valid  s_data valid
//     s_ready  loader accepts a word this cycle
//     wr_en    one-cycle write strobe into the selected bank
//     wr_bank  0 sigmoid, 1 tanh, 2 bfc, 3 wfc, 4 blstm, 5 ulstm, 6 wlstm
//     wr_addr  word address within the bank
//     wr_data  word to write
//   Modports:
//     master  host/DMA side: drives the stream and observes the write bus
//     slave   the loader: consumes the stream and drives the write bus
interface weight_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);

  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  logic                  wr_en;
  logic [2:0]            wr_bank;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  wr_en,
    input  wr_bank,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output wr_en,
    output wr_bank,
    output wr_addr,
    output wr_data
  );

endinterface

// File: rtl/weight_loader.sv
// weight_loader
//   Runtime writer for the LSTM/FC weight and activation LUT banks. Accepts a
//   valid/ready word stream made of one header word followed by a payload of
//   'count' words, and turns each accepted payload word into a registered
//   write strobe into the bank named by the header. Used to update weights in
//   place instead of preloading the banks from files.
//
//   Header word: bank = [2:0], bank usable only when [3] == 0 and bank <= 6,
//   count = [31:16] payload words (1..65535; 0 is an error).
//
//   Ports:
//     clk      single clock, rising edge
//     rst_n    asynchronous, active-low reset (aborts a load, no rollback)
//     bus      weight_loader_if.slave: stream in, bank write bus out
//     err_clr  clears the sticky error flag (a same-cycle set wins)
//     busy     high while loading a payload or finishing it
//     done     one-cycle pulse together with the final payload write
//     err      sticky error: zero count, bad bank or bank overflow
module weight_loader #(
  parameter int DATA_WIDTH  = 32,
  parameter int LUT_DEPTH   = 16,
  parameter int BFC_DEPTH   = 1,
  parameter int WFC_DEPTH   = 4,
  parameter int BLSTM_DEPTH = 16,
  parameter int ULSTM_DEPTH = 32,
  parameter int WLSTM_DEPTH = 64,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  weight_loader_if.slave  bus,
  input  logic            err_clr,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic [2:0]            bank_q;
  logic                  bankOk_q;
  logic [15:0]           count_q;
  logic [15:0]           idx_q;

  logic                  wrEn_q;
  logic [2:0]            wrBank_q;
  logic [ADDR_WIDTH-1:0] wrAddr_q;
  logic [DATA_WIDTH-1:0] wrData_q;
  logic                  done_q;
  logic                  err_q;
  logic                  err_d;

  logic                  xfer;
  logic [15:0]           hdrCount;
  logic [2:0]            hdrBank;
  logic                  hdrOk;
  logic                  inRange;
  logic                  lastWord;
  logic                  errSet;

  // Depth of each bank; bank 7 has no storage behind it.
  function automatic logic [16:0] bankDepth(input logic [2:0] bank);
    logic [16:0] depth;
    unique case (bank)
      3'd0, 3'd1: depth = 17'(LUT_DEPTH);
      3'd2:       depth = 17'(BFC_DEPTH);
      3'd3:       depth = 17'(WFC_DEPTH);
      3'd4:       depth = 17'(BLSTM_DEPTH);
      3'd5:       depth = 17'(ULSTM_DEPTH);
      3'd6:       depth = 17'(WLSTM_DEPTH);
      default:    depth = 17'd0;
    endcase
    return depth;
  endfunction

  assign xfer     = bus.s_valid & bus.s_ready;
  assign hdrCount = bus.s_data[31:16];
  assign hdrBank  = bus.s_data[2:0];
  assign hdrOk    = ~bus.s_data[3] & (hdrBank != 3'd7);

  // The full 16-bit index is compared against the depth, so a word past the
  // end of the bank is dropped rather than wrapping onto a low address.
  assign inRange  = bankOk_q & ({1'b0, idx_q} < bankDepth(bank_q));
  assign lastWord = (idx_q == (count_q - 16'd1));

  // Error sources: a zero-length header, or a payload word that cannot be
  // written (bad bank or past the bank depth). Setting beats clearing.
  assign errSet = xfer & (((state_q == IDLE) & (hdrCount == 16'd0)) |
                          ((state_q == LOAD) & ~inRange));
  assign err_d  = errSet ? 1'b1 : (err_clr ? 1'b0 : err_q);

  // Main control: header capture, payload indexing and the registered write
  // strobe. The write bus holds its last value whenever wr_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bank_q   <= 3'd0;
      bankOk_q <= 1'b0;
      count_q  <= 16'd0;
      idx_q    <= 16'd0;
      wrEn_q   <= 1'b0;
      wrBank_q <= 3'd0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wrEn_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= err_d;
      unique case (state_q)
        IDLE: begin
          if (xfer) begin
            bank_q   <= hdrBank;
            bankOk_q <= hdrOk;
            count_q  <= hdrCount;
            idx_q    <= 16'd0;
            if (hdrCount != 16'd0) begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            if (inRange) begin
              wrEn_q   <= 1'b1;
              wrBank_q <= bank_q;
              wrAddr_q <= idx_q[ADDR_WIDTH-1:0];
              wrData_q <= bus.s_data;
            end
            idx_q <= idx_q + 16'd1;
            // done lands in the same cycle as the final write strobe.
            if (lastWord) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Ready is low only for the single DONE cycle, which keeps the final write
  // of one packet from sharing a cycle with the header of the next.
  assign bus.s_ready = rst_n & (state_q != DONE);
  assign bus.wr_en   = wrEn_q;
  assign bus.wr_bank = wrBank_q;
  assign bus.wr_addr = wrAddr_q;
  assign bus.wr_data = wrData_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_weight_loader.sv
module tb_weight_loader;

  localparam int DW = 32;
  localparam int AW = 6;

  logic clk     = 1'b0;
  logic rst_n   = 1'b1;
  logic err_clr = 1'b0;
  logic busy;
  logic done;
  logic err;

  weight_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  weight_loader #(
    .DATA_WIDTH(DW),
    .LUT_DEPTH(16),
    .BFC_DEPTH(1),
    .WFC_DEPTH(4),
    .BLSTM_DEPTH(16),
    .ULSTM_DEPTH(32),
    .WLSTM_DEPTH(64),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .err_clr(err_clr),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  // Observed DUT activity, used by the hand-computed per-test expectations.
  int            nWrites  = 0;
  int            nDones   = 0;
  logic [2:0]    lastBank = 3'd0;
  logic [AW-1:0] lastAddr = '0;
  logic [DW-1:0] lastData = '0;

  // Packet-level reference model: words still owed by the current header,
  // index of the next payload word, and a one-cycle turnaround after a packet.
  int            mRemaining = 0;
  int            mIdx       = 0;
  int            mXfer      = 0;
  int            mCnt       = 0;
  bit            mCooldown  = 1'b0;
  bit            mBad       = 1'b0;
  bit            mSetErr    = 1'b0;
  logic [2:0]    mBank      = 3'd0;
  logic          expWrEn    = 1'b0;
  logic          expDone    = 1'b0;
  logic          expErr     = 1'b0;
  logic [2:0]    expBank    = 3'd0;
  logic [AW-1:0] expAddr    = '0;
  logic [DW-1:0] expData    = '0;

  function automatic int depthOf(input logic [2:0] b);
    case (b)
      3'd0, 3'd1: return 16;
      3'd2:       return 1;
      3'd3:       return 4;
      3'd4:       return 16;
      3'd5:       return 32;
      3'd6:       return 64;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] hdr(input logic [3:0] b, input logic [15:0] c);
    return {c, 12'h5A0, b};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model update, one step per clock edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mRemaining = 0;
      mIdx       = 0;
      mCooldown  = 1'b0;
      mBad       = 1'b0;
      mBank      = 3'd0;
      expWrEn    = 1'b0;
      expDone    = 1'b0;
      expErr     = 1'b0;
      expBank    = 3'd0;
      expAddr    = '0;
      expData    = '0;
    end else begin
      mSetErr = 1'b0;
      expWrEn = 1'b0;
      expDone = 1'b0;
      if (mCooldown) begin
        mCooldown = 1'b0;
      end else if (bus.s_valid) begin
        mXfer++;
        if (mRemaining == 0) begin
          mCnt = int'(bus.s_data[31:16]);
          if (mCnt == 0) begin
            mSetErr = 1'b1;
          end else begin
            mBank      = bus.s_data[2:0];
            mBad       = bus.s_data[3] || (depthOf(mBank) == 0);
            mRemaining = mCnt;
            mIdx       = 0;
          end
        end else begin
          if (!mBad && mIdx < depthOf(mBank)) begin
            expWrEn = 1'b1;
            expBank = mBank;
            expAddr = AW'(mIdx);
            expData = bus.s_data;
          end else begin
            mSetErr = 1'b1;
          end
          mIdx++;
          mRemaining--;
          if (mRemaining == 0) begin
            expDone   = 1'b1;
            mCooldown = 1'b1;
          end
        end
      end
      if (mSetErr) expErr = 1'b1;
      else if (err_clr) expErr = 1'b0;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("wr_en", 32'(bus.wr_en), 32'(expWrEn));
      checkOutput("wr_bank", 32'(bus.wr_bank), 32'(expBank));
      checkOutput("wr_addr", 32'(bus.wr_addr), 32'(expAddr));
      checkOutput("wr_data", bus.wr_data, expData);
      checkOutput("done", 32'(done), 32'(expDone));
      checkOutput("err", 32'(err), 32'(expErr));
      checkOutput("busy", 32'(busy), 32'((mRemaining != 0) || mCooldown));
      checkOutput("s_ready", 32'(bus.s_ready), 32'(!mCooldown));
      if (bus.wr_en) begin
        nWrites++;
        lastBank = bus.wr_bank;
        lastAddr = bus.wr_addr;
        lastData = bus.wr_data;
      end
      if (done) nDones++;
    end
  end

  // Present one word until the stream accepts it, then drop valid.
  task automatic applyStimulus(input logic [31:0] word, input bit clr);
    int start;
    int budget;
    start       = mXfer;
    budget      = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = word;
    err_clr     = clr;
    do begin
      @(posedge clk);
      #1;
      budget++;
    end while (mXfer == start && budget < 20);
    if (mXfer == start) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL accept_timeout: word %h not accepted after %0d cycles", word, budget);
    end
    bus.s_valid = 1'b0;
    bus.s_data  = $urandom;
    err_clr     = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    bus.s_data  = $urandom;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearErr();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    idle(1);
  endtask

  int w0;
  int d0;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    $display("[TB] weight_loader bench starting");
    #1 rst_n = 1'b0;
    idle(2);
    checkOutput("rst_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle(1);
    checkOutput("rst_s_ready", 32'(bus.s_ready), 32'd1);

    // T1: reset in the middle of a bank 6 load
    applyStimulus(hdr(4'd6, 16'd10), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(32'h1100_0000 + i, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t1_wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("t1_wr_bank", 32'(bus.wr_bank), 32'd0);
    checkOutput("t1_wr_addr", 32'(bus.wr_addr), 32'd0);
    checkOutput("t1_wr_data", bus.wr_data, 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    checkOutput("t1_done", 32'(done), 32'd0);
    checkOutput("t1_err", 32'(err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    checkOutput("t1_s_ready", 32'(bus.s_ready), 32'd1);
    w0 = nWrites;
    applyStimulus(hdr(4'd4, 16'd2), 1'b0);
    applyStimulus(32'h4444_0000, 1'b0);
    idle(1);
    checkOutput("t1_first_addr", 32'(lastAddr), 32'd0);
    applyStimulus(32'h4444_0001, 1'b0);
    idle(2);
    checkOutput("t1_writes", 32'(nWrites - w0), 32'd2);
    checkOutput("t1_last_bank", 32'(lastBank), 32'd4);

    // T2: wfc bank, four words back-to-back
    w0 = nWrites; d0 = nDones;
    applyStimulus(hdr(4'd3, 16'd4), 1'b0);
    applyStimulus(32'hAAAA_000A, 1'b0);
    applyStimulus(32'hBBBB_000B, 1'b0);
    applyStimulus(32'hCCCC_000C, 1'b0);
    applyStimulus(32'hDDDD_000D, 1'b0);
    idle(2);
    checkOutput("t2_writes", 32'(nWrites - w0), 32'd4);
    checkOutput("t2_dones", 32'(nDones - d0), 32'd1);
    checkOutput("t2_last_addr", 32'(lastAddr), 32'd3);
    checkOutput("t2_last_data", lastData, 32'hDDDD_000D);
    checkOutput("t2_err", 32'(err), 32'd0);

    // T3: bfc bank of depth 1 receiving three words
    w0 = nWrites; d0 = nDones;
    applyStimulus(hdr(4'd2, 16'd3), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(32'h2222_0000 + i, 1'b0);
    idle(2);
    checkOutput("t3_writes", 32'(nWrites - w0), 32'd1);
    checkOutput("t3_dones", 32'(nDones - d0), 32'd1);
    checkOutput("t3_last_data", lastData, 32'h2222_0000);
    checkOutput("t3_err", 32'(err), 32'd1);
    clearErr();
    checkOutput("t3_err_clr", 32'(err), 32'd0);

    // T4: bank 7, then bank 3 with the reserved bit set
    w0 = nWrites; d0 = nDones;
    applyStimulus(hdr(4'd7, 16'd2), 1'b0);
    applyStimulus(32'h7777_0000, 1'b0);
    applyStimulus(32'h7777_0001, 1'b0);
    idle(2);
    checkOutput("t4_writes", 32'(nWrites - w0), 32'd0);
    checkOutput("t4_dones", 32'(nDones - d0), 32'd1);
    checkOutput("t4_err", 32'(err), 32'd1);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    clearErr();
    applyStimulus(hdr(4'hB, 16'd1), 1'b0);
    applyStimulus(32'hBAD0_0000, 1'b0);
    idle(2);
    checkOutput("t4_rsvd_writes", 32'(nWrites - w0), 32'd0);
    checkOutput("t4_rsvd_err", 32'(err), 32'd1);
    clearErr();

    // T5: zero-length header, then a full wlstm load with random gaps
    w0 = nWrites; d0 = nDones;
    applyStimulus(hdr(4'd5, 16'd0), 1'b0);
    idle(2);
    checkOutput("t5_zero_err", 32'(err), 32'd1);
    checkOutput("t5_zero_dones", 32'(nDones - d0), 32'd0);
    checkOutput("t5_zero_busy", 32'(busy), 32'd0);
    clearErr();
    applyStimulus(hdr(4'd6, 16'd64), 1'b0);
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      applyStimulus(32'h6600_0000 + i, 1'b0);
    end
    idle(2);
    checkOutput("t5_writes", 32'(nWrites - w0), 32'd64);
    checkOutput("t5_last_addr", 32'(lastAddr), 32'd63);
    checkOutput("t5_last_data", lastData, 32'h6600_003F);
    checkOutput("t5_dones", 32'(nDones - d0), 32'd1);
    checkOutput("t5_err", 32'(err), 32'd0);

    // T6: overflow word accepted in the same cycle as err_clr
    w0 = nWrites;
    applyStimulus(hdr(4'd3, 16'd6), 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(32'h3300_0000 + i, 1'b0);
    applyStimulus(32'h3300_0005, 1'b1);
    idle(2);
    checkOutput("t6_writes", 32'(nWrites - w0), 32'd4);
    checkOutput("t6_err_kept", 32'(err), 32'd1);
    clearErr();
    checkOutput("t6_err_clr", 32'(err), 32'd0);

    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got time %0t, required below 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
